// File: rtl/somador_serial.sv
// Bit-serial two's-complement adder/subtractor: LSB-first, one result bit per clock.
// Optional saturation on signed overflow is compiled in with `define SOMADOR_SERIAL_SAT_EN.
//
// Handshake: start is sampled only while idle (busy=0), and A, B and sub are captured
// on that same edge. busy stays high from the capture edge until the result is
// published. done is a one-cycle pulse, and S/Z/N/P/V/C are valid from that pulse
// onward. A new start may be presented in the same cycle as done.
module somador_serial #(
    parameter int NUM_BITS = 8
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic                sub,
    input  logic [NUM_BITS-1:0] A,
    input  logic [NUM_BITS-1:0] B,
    output logic                busy,
    output logic                done,
    output logic [NUM_BITS-1:0] S,
    output logic                Z,
    output logic                N,
    output logic                P,
    output logic                V,
    output logic                C,
    output logic [1:0]          dbg_state
);

    localparam int CW = (NUM_BITS > 2) ? $clog2(NUM_BITS) : 1;
    localparam logic [CW-1:0] LAST = CW'(NUM_BITS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state;
    logic [NUM_BITS-1:0] a_sr;
    logic [NUM_BITS-1:0] b_sr;
    logic [NUM_BITS-1:0] res;
    logic [CW-1:0]       cnt;
    logic                carry;
    logic                a_msb;
    logic                b_msb;

    logic                sum_bit;
    logic                carry_nxt;
    logic                raw_v;
    logic [NUM_BITS-1:0] s_final;

    assign dbg_state = state;

    // One full-adder slice, reused every RUN cycle on the current LSBs.
    always_comb begin
        sum_bit   = a_sr[0] ^ b_sr[0] ^ carry;
        carry_nxt = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry) | (b_sr[0] & carry);
    end

    // The operand sign bits are shifted out of the registers, so they are kept separately.
    assign raw_v = (a_msb == b_msb) && (res[NUM_BITS-1] != a_msb);

`ifdef SOMADOR_SERIAL_SAT_EN
    always_comb begin
        s_final = res;
        if (raw_v) begin
            if (a_msb) s_final = {1'b1, {(NUM_BITS-1){1'b0}}};
            else       s_final = {1'b0, {(NUM_BITS-1){1'b1}}};
        end
    end
`else
    assign s_final = res;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            a_sr  <= '0;
            b_sr  <= '0;
            res   <= '0;
            cnt   <= '0;
            carry <= 1'b0;
            a_msb <= 1'b0;
            b_msb <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            S     <= '0;
            Z     <= 1'b0;
            N     <= 1'b0;
            P     <= 1'b0;
            V     <= 1'b0;
            C     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sr  <= A;
                        b_sr  <= B ^ {NUM_BITS{sub}};
                        carry <= sub;
                        cnt   <= '0;
                        res   <= '0;
                        a_msb <= A[NUM_BITS-1];
                        b_msb <= B[NUM_BITS-1] ^ sub;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    res   <= {sum_bit, res[NUM_BITS-1:1]};
                    a_sr  <= a_sr >> 1;
                    b_sr  <= b_sr >> 1;
                    carry <= carry_nxt;
                    cnt   <= cnt + CW'(1);
                    if (cnt == LAST) state <= DONE;
                end
                DONE: begin
                    S     <= s_final;
                    Z     <= (s_final == '0);
                    N     <= s_final[NUM_BITS-1];
                    P     <= ~s_final[0];
                    V     <= raw_v;
                    C     <= carry;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_somador_serial.sv
// Bench for somador_serial: directed and random add/subtract operations checked
// against an integer-arithmetic reference model, plus latency, busy, ignored-start and reset checks.
module tb_somador_serial;

    localparam int NB  = 8;
    localparam int MOD = 2 ** NB;

    logic          clock;
    logic          reset;
    logic          start;
    logic          sub;
    logic [NB-1:0] A;
    logic [NB-1:0] B;
    logic          busy;
    logic          done;
    logic [NB-1:0] S;
    logic          Z, N, P, V, C;
    logic [1:0]    dbg_state;

    int n_tests = 0;
    int n_fail  = 0;
    logic [NB-1:0] prev_s;
    logic [4:0]    prev_f;
    logic [NB+4:0] exp_q[$];

    somador_serial #(.NUM_BITS(NB)) dut (
        .clock(clock), .reset(reset), .start(start), .sub(sub), .A(A), .B(B),
        .busy(busy), .done(done), .S(S), .Z(Z), .N(N), .P(P), .V(V), .C(C),
        .dbg_state(dbg_state)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: plain modular arithmetic, returns {S, Z, N, P, V, C}.
    function automatic logic [NB+4:0] model(input int a, input int b, input int s);
        int bb, full, r, res;
        bit a_neg, b_neg, r_neg, v, c;
        bb    = s ? (MOD - 1 - b) : b;
        full  = a + bb + s;
        r     = full % MOD;
        c     = (full >= MOD);
        a_neg = (a >= MOD / 2);
        b_neg = (bb >= MOD / 2);
        r_neg = (r >= MOD / 2);
        v     = (a_neg == b_neg) && (r_neg != a_neg);
        res   = r;
`ifdef SOMADOR_SERIAL_SAT_EN
        if (v) res = a_neg ? MOD / 2 : MOD / 2 - 1;
`endif
        model = {NB'(res), res == 0, res >= MOD / 2, (res % 2) == 0, v, c};
    endfunction

    // Runs one operation; repulse>0 re-asserts start (with A=50) that many cycles into the operation.
    task automatic run_op(input logic [NB-1:0] a, input logic [NB-1:0] b, input logic s, input int repulse);
        logic [NB+4:0] e;
        @(negedge clock);
        A = a; B = b; sub = s; start = 1'b1;
        exp_q.push_back(model(int'(a), int'(b), int'(s)));
        @(posedge clock); #1;
        start = 1'b0;
        A = NB'($urandom); B = NB'($urandom); sub = 1'($urandom);
        check("busy_after_start", busy, 1);
        check("done_low_after_start", done, 0);
        for (int i = 1; i <= NB + 1; i++) begin
            @(posedge clock); #1;
            start = 1'b0;
            A = NB'($urandom); B = NB'($urandom); sub = 1'($urandom);
            if (i == repulse) begin
                start = 1'b1;
                A = 8'd50;
            end
            if (i <= NB) begin
                check("busy_run", busy, 1);
                check("done_early", done, 0);
                check("s_hold_run", S, prev_s);
                check("flags_hold_run", {Z, N, P, V, C}, prev_f);
            end else begin
                e = exp_q.pop_front();
                check("done_pulse", done, 1);
                check("busy_at_done", busy, 0);
                check("s_result", S, e[NB+4:5]);
                check("flags_zn_p_v_c", {Z, N, P, V, C}, e[4:0]);
                prev_s = e[NB+4:5];
                prev_f = e[4:0];
            end
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; sub = 1'b0; A = '0; B = '0;
        prev_s = '0; prev_f = '0;
        repeat (3) @(posedge clock);
        #1;
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_s", S, 0);
        check("reset_flags", {Z, N, P, V, C}, 0);
        @(negedge clock); reset = 1'b0;

        run_op(8'd5, 8'd3, 1'b0, 0);
        check("add_5_3_s", S, 8);
        check("add_5_3_flags", {Z, N, P, V, C}, 5'b00100);
        run_op(8'd100, 8'd100, 1'b0, 0);
        check("add_100_100_v", V, 1);
        check("add_100_100_c", C, 0);
        run_op(8'd3, 8'd3, 1'b1, 0);
        check("sub_3_3_flags", {Z, N, P, V, C}, 5'b10101);
        run_op(8'h80, 8'd1, 1'b1, 0);
        check("sub_m128_1_v", V, 1);
        run_op(8'd7, 8'd1, 1'b0, 3);
        check("ignored_start_s", S, 8);
        // The start pulsed during busy must not have launched a second operation.
        @(posedge clock); #1;
        check("no_extra_op_busy", busy, 0);
        repeat (NB + 2) begin
            @(posedge clock); #1;
            check("no_extra_done", done, 0);
        end

        // Boundary operands, then random ones.
        run_op(8'h7f, 8'h01, 1'b0, 0);
        run_op(8'h00, 8'h00, 1'b1, 0);
        run_op(8'hff, 8'h01, 1'b0, 0);
        run_op(8'h7f, 8'h80, 1'b1, 0);
        for (int k = 0; k < 40; k++)
            run_op(NB'($urandom_range(0, MOD - 1)), NB'($urandom_range(0, MOD - 1)),
                   1'($urandom_range(0, 1)), 0);

        // Abort mid-operation with reset.
        @(negedge clock);
        A = 8'd20; B = 8'd30; sub = 1'b0; start = 1'b1;
        @(posedge clock); #1; start = 1'b0;
        repeat (4) @(posedge clock);
        #1 reset = 1'b1;
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_s", S, 0);
        check("abort_flags", {Z, N, P, V, C}, 0);
        prev_s = '0; prev_f = '0;
        repeat (2) @(posedge clock);
        @(negedge clock); reset = 1'b0;
        repeat (NB + 2) begin
            @(posedge clock); #1;
            check("abort_no_done", done, 0);
        end
        run_op(8'hff, 8'hff, 1'b0, 0);
        check("after_reset_s", S, 8'hfe);
        check("after_reset_flags", {Z, N, P, V, C}, 5'b01101);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/somador_serial.md
SOMADOR_SERIAL -- requirements
Module: somador_serial

Interface
REQ-001 The block SHALL have parameter NUM_BITS, default 8, giving the operand and result width in bits (legal range 2..32).
REQ-002 The block SHALL have port clock, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit, asynchronous active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit, a request to begin an operation; sampled only in IDLE.
REQ-005 The block SHALL have port sub, input, 1 bit, selecting the operation: 0 = A+B, 1 = A-B; sampled with start.
REQ-006 The block SHALL have ports A and B, inputs, NUM_BITS bits each, signed two's-complement operands sampled with start.
REQ-007 The block SHALL have port busy, output, 1 bit, high while in RUN or DONE.
REQ-008 The block SHALL have port done, output, 1 bit, a single-cycle pulse marking that the result is valid.
REQ-009 The block SHALL have port S, output, NUM_BITS bits, the signed result.
REQ-010 The block SHALL have ports Z, N, P, V and C, outputs, 1 bit each: zero, negative, even, signed overflow and carry-out.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-012 IDLE->RUN SHALL occur when start=1, which latches A, B^{NUM_BITS{sub}} into shift registers, sets carry=sub and clears the bit counter.
REQ-013 In RUN, each cycle SHALL compute one result bit LSB-first with a full adder: sum bit shifted into the result register, carry registered, counter incremented.
REQ-014 RUN->DONE SHALL occur after exactly NUM_BITS RUN cycles (counter reaching NUM_BITS-1).
REQ-015 In DONE, the outputs S, Z, N, P, V and C SHALL be loaded from the completed result, done=1 for that one cycle, then the FSM SHALL return to IDLE.
REQ-016 Latency SHALL be fixed: if start is sampled at edge k, done is high in the cycle following edge k+NUM_BITS+1.
REQ-017 start SHALL be ignored while busy=1; A, B and sub changes during busy SHALL NOT affect the result.
REQ-018 start may be asserted in the IDLE cycle immediately after DONE (back-to-back operations allowed).
REQ-019 Flag definitions on the raw (unsaturated) sum R: Z=(S==0); N=S[NUM_BITS-1]; P=~S[0]; V=(opA_msb==opB'_msb)&&(R_msb!=opA_msb), where opB' is the possibly-inverted B; C=final carry (for subtraction C=1 means no borrow).
REQ-020 S and the flags SHALL hold their last value between done pulses and SHALL be unchanged while in RUN.
REQ-021 Arithmetic SHALL be modulo 2^NUM_BITS unless the saturation feature is compiled in.

Reset
REQ-022 reset=1 SHALL asynchronously force state IDLE and busy=0, done=0, S=0, Z=0, N=0, P=0, V=0, C=0, and clear the counter, carry and shift registers.
REQ-023 reset asserted mid-operation SHALL abort that operation with no done pulse; the first start after reset release SHALL be processed normally.

Configuration
REQ-024 The macro SOMADOR_SERIAL_SAT_EN, when defined, SHALL saturate S on V=1: S = 2^(NUM_BITS-1)-1 when opA is positive, and S = -2^(NUM_BITS-1) when opA is negative; Z, N and P are computed from the saturated S; V and C still report the raw sum.
REQ-025 Without SOMADOR_SERIAL_SAT_EN, S SHALL be the wrapped raw sum and no saturation logic SHALL be present.

Verification (NUM_BITS=8)
REQ-026 start with A=5, B=3, sub=0 -> done 9 cycles after the start edge; S=8, Z=0, N=0, P=1, V=0, C=0; busy high for the 9 intervening cycles.
REQ-027 A=100, B=100, sub=0 -> V=1, C=0; without SAT_EN S=-56 (0xC8), N=1, P=1; with SAT_EN S=127, N=0, P=0.
REQ-028 A=3, B=3, sub=1 -> S=0, Z=1, N=0, P=1, V=0, C=1; then A=-128, B=1, sub=1 -> V=1; S=127 without SAT_EN, S=-128 with SAT_EN.
REQ-029 start with A=7, B=1; re-pulse start with A=50 at cycle 3 -> still exactly one done pulse with S=8; the second start is ignored.
REQ-030 Assert reset at RUN cycle 4 -> all outputs return to 0 immediately with no done pulse; a following start with A=-1, B=-1 -> S=-2, N=1, P=1, C=1, V=0.
